// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// flush-to-bubble, and a saturating back-pressure cycle counter.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  input  logic              flush_i,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_main, r_skid, w_main_nxt, w_skid_nxt;
  logic              r_rdy;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_in_fire, w_out_fire;

  assign valid_o     = (r_state != S_EMPTY);
  assign data_o      = r_main;
  assign stall_cnt_o = r_cnt;
  // Skid mode decouples ready_o from ready_i; plain mode passes it through.
  assign ready_o     = (SKID != 0) ? r_rdy : (!valid_o | ready_i);
  assign w_in_fire   = valid_i & ready_o;
  assign w_out_fire  = valid_o & ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (SKID != 0) begin
      case (r_state)
        S_EMPTY: if (w_in_fire) begin
          w_state_nxt = S_ONE;
          w_main_nxt  = data_i;
        end
        S_ONE: begin
          if (w_in_fire && !w_out_fire) begin
            w_state_nxt = S_TWO;
            w_skid_nxt  = data_i;
          end else if (w_in_fire) begin
            w_main_nxt  = data_i;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: if (w_out_fire) begin
          w_state_nxt = S_ONE;
          w_main_nxt  = r_skid;
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end else begin
      // S_ONE doubles as FULL; S_TWO is unreachable without the skid entry.
      if (w_in_fire) begin
        w_state_nxt = S_ONE;
        w_main_nxt  = data_i;
      end else if (w_out_fire) begin
        w_state_nxt = S_EMPTY;
      end
    end
    if (flush_i) w_state_nxt = S_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_rdy   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      r_rdy   <= (w_state_nxt != S_TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr_i)
      r_cnt <= '0;
    else if (valid_o && !ready_i && (r_cnt != '1))
      r_cnt <= r_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised checks of pipe_stage_reg in skid (CNT_W=4) and
// plain (SKID=0) builds against hand-computed values and a beat queue model.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        v1, r1, f1, c1, ro1, vo1;
  logic [31:0] d1, do1;
  logic [3:0]  so1;
  logic        v0, r0, f0, c0, ro0, vo0;
  logic [31:0] d0, do0;
  logic [15:0] so0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] q1[$];
  logic [31:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(4)) u_s1 (
    .clk(clk), .rst(rst), .valid_i(v1), .ready_o(ro1), .data_i(d1),
    .valid_o(vo1), .ready_i(r1), .data_o(do1), .flush_i(f1),
    .cnt_clr_i(c1), .stall_cnt_o(so1));

  pipe_stage_reg #(.DATA_W(32), .SKID(0), .CNT_W(16)) u_s0 (
    .clk(clk), .rst(rst), .valid_i(v0), .ready_o(ro0), .data_i(d0),
    .valid_o(vo0), .ready_i(r0), .data_o(do0), .flush_i(f0),
    .cnt_clr_i(c0), .stall_cnt_o(so0));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic inf1, outf1, inf0, outf0;
    rst = 1'b1;
    v1 = 1'b1; d1 = 32'hDEADBEEF; r1 = 1'b1; f1 = 1'b0; c1 = 1'b0;
    v0 = 1'b1; d0 = 32'hDEADBEEF; r0 = 1'b1; f0 = 1'b0; c0 = 1'b0;

    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_vo1", vo1, 0); chk("rst_ro1", ro1, 1);
      chk("rst_do1", do1, 0); chk("rst_so1", so1, 0);
      chk("rst_vo0", vo0, 0); chk("rst_do0", do0, 0);
      chk("rst_so0", so0, 0);
    end
    rst = 1'b0; v1 = 1'b0; v0 = 1'b0;
    #1;
    chk("rst_ro0", ro0, 1);

    // Back-to-back streaming, both builds
    for (int k = 1; k <= 8; k++) begin
      v1 = 1'b1; d1 = 32'(k); v0 = 1'b1; d0 = 32'(k);
      tick();
      chk("str_vo1", vo1, 1); chk("str_do1", do1, 32'(k)); chk("str_ro1", ro1, 1);
      chk("str_vo0", vo0, 1); chk("str_do0", do0, 32'(k));
    end
    v1 = 1'b0; v0 = 1'b0;
    tick();
    chk("str_end_vo1", vo1, 0); chk("str_end_vo0", vo0, 0);

    // Skid back-pressure: A, B fill the stage, C waits at the input
    r1 = 1'b0; v1 = 1'b1; d1 = 32'hA;
    tick();
    chk("bp_do_a", do1, 32'hA); chk("bp_ro_one", ro1, 1); chk("bp_so0", so1, 0);
    d1 = 32'hB;
    tick();
    chk("bp_ro_two", ro1, 0); chk("bp_do_a2", do1, 32'hA); chk("bp_so1", so1, 1);
    d1 = 32'hC;
    tick();
    chk("bp_ro_hold", ro1, 0); chk("bp_so2", so1, 2);
    tick();
    chk("bp_so3", so1, 3);
    r1 = 1'b1;
    tick();
    chk("bp_do_b", do1, 32'hB); chk("bp_ro_up", ro1, 1); chk("bp_so_hold", so1, 3);
    tick();
    chk("bp_do_c", do1, 32'hC); chk("bp_vo_c", vo1, 1);
    v1 = 1'b0;
    tick();
    chk("bp_drain", vo1, 0); chk("bp_so_final", so1, 3);

    // Flush from TWO while the output is delivering
    r1 = 1'b0; v1 = 1'b1; d1 = 32'h1;
    tick();
    d1 = 32'h2;
    tick();
    chk("fl_ro_two", ro1, 0); chk("fl_so_pre", so1, 4);
    f1 = 1'b1; d1 = 32'h55; r1 = 1'b1;
    tick();
    chk("fl_vo", vo1, 0); chk("fl_ro", ro1, 1); chk("fl_so", so1, 4);
    f1 = 1'b0; v1 = 1'b0;
    tick();
    chk("fl_no55", vo1, 0);
    // Flush from ONE swallows an accepted beat
    v1 = 1'b1; d1 = 32'h77; r1 = 1'b0;
    tick();
    chk("fl1_do", do1, 32'h77);
    f1 = 1'b1; d1 = 32'h88;
    tick();
    chk("fl1_vo", vo1, 0); chk("fl1_ro", ro1, 1); chk("fl1_so", so1, 5);
    f1 = 1'b0; v1 = 1'b0;
    tick();
    chk("fl1_no88", vo1, 0);

    // Counter saturation and clear
    v1 = 1'b1; d1 = 32'h9;
    tick();
    v1 = 1'b0;
    repeat (20) tick();
    chk("sat_f", so1, 4'hF); chk("sat_do", do1, 32'h9);
    c1 = 1'b1;
    tick();
    chk("sat_clr", so1, 0);
    c1 = 1'b0;
    tick();
    chk("sat_resume", so1, 1);
    r1 = 1'b1;
    tick();
    chk("sat_drain", vo1, 0);

    // Plain build: combinational ready under back-pressure
    r0 = 1'b0; v0 = 1'b1; d0 = 32'hA;
    tick();
    chk("p_do_a", do0, 32'hA); chk("p_ro_lo", ro0, 0);
    d0 = 32'hB;
    tick();
    chk("p_hold_a", do0, 32'hA); chk("p_so", so0, 1);
    r0 = 1'b1;
    #1;
    chk("p_ro_comb", ro0, 1);
    tick();
    chk("p_do_b", do0, 32'hB);
    v0 = 1'b0;
    tick();
    chk("p_drain", vo0, 0);

    // Random traffic against a queue model of accepted, unflushed beats
    for (int n = 0; n < 10000; n++) begin
      v1 = 1'($urandom_range(0, 1)); r1 = ($urandom_range(0, 3) != 0);
      f1 = ($urandom_range(0, 15) == 0); d1 = $urandom;
      v0 = 1'($urandom_range(0, 1)); r0 = ($urandom_range(0, 3) != 0);
      f0 = ($urandom_range(0, 15) == 0); d0 = $urandom;
      #1;
      chk("rnd_vo1", vo1, (q1.size() != 0));
      chk("rnd_ro1", ro1, (q1.size() < 2));
      if (q1.size() != 0) chk("rnd_do1", do1, q1[0]);
      chk("rnd_vo0", vo0, (q0.size() != 0));
      chk("rnd_ro0", ro0, (q0.size() == 0) || r0);
      if (q0.size() != 0) chk("rnd_do0", do0, q0[0]);
      inf1 = v1 & ro1; outf1 = vo1 & r1;
      inf0 = v0 & ro0; outf0 = vo0 & r0;
      if (outf1 && q1.size() != 0) void'(q1.pop_front());
      if (inf1) q1.push_back(d1);
      if (f1) q1.delete();
      if (outf0 && q0.size() != 0) void'(q0.pop_front());
      if (inf0) q0.push_back(d0);
      if (f0) q0.delete();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
